// File: rtl/hold_sweep_pkg.sv
// Shared types and default constants for the hold-time sweep sequencer.
package hold_sweep_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SETTLE,
      LAUNCH,
      WAIT_FIN,
      EVAL,
      DONE
   } sweep_state_t;

   localparam int DEF_DW          = 8;
   localparam int DEF_CODE_MIN    = 0;
   localparam int DEF_CODE_MAX    = 255;
   localparam int DEF_SETTLE_CYC  = 16;
   localparam int DEF_TIMEOUT_CYC = 1024;

   // Shared settle / watchdog counter width
   localparam int CNT_W = 16;

endpackage

// File: rtl/hold_sweep_ctrl_if.sv
// Handshake bundle between the sweep sequencer (master) and the analog bench side (slave).
interface hold_sweep_ctrl_if
   import hold_sweep_pkg::*;
#(
   parameter int DW = DEF_DW
);

   logic          start;
   logic          abort;
   logic          fin_test;
   logic          q_ok;
   logic [DW-1:0] delay_code;
   logic          launch;
   logic          busy;
   logic          done;
   logic [DW-1:0] hold_code;
   logic          no_pass;
   logic          timeout_err;
   logic [DW-1:0] trial_cnt;

   modport master (
      input  start, abort, fin_test, q_ok,
      output delay_code, launch, busy, done, hold_code, no_pass, timeout_err, trial_cnt
   );

   modport slave (
      output start, abort, fin_test, q_ok,
      input  delay_code, launch, busy, done, hold_code, no_pass, timeout_err, trial_cnt
   );

endinterface

// File: rtl/hold_sweep_sync.sv
// Two-flop synchroniser for asynchronous bench flags; resets to 0.
module hold_sweep_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/hold_sweep_ctrl.sv
// Binary-search sequencer that finds the smallest passing D-fall delay code.
// Optional watchdog on fin_test is enabled by defining HOLD_SWEEP_TIMEOUT_EN.
module hold_sweep_ctrl
   import hold_sweep_pkg::*;
#(
   parameter int DW          = DEF_DW,
   parameter int CODE_MIN    = DEF_CODE_MIN,
   parameter int CODE_MAX    = DEF_CODE_MAX,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic               clk,
   input  logic               rst_n,
   hold_sweep_ctrl_if.master  bus
);

   localparam logic [DW-1:0] LO_INIT   = DW'(CODE_MIN);
   localparam logic [DW-1:0] HI_INIT   = DW'(CODE_MAX);
   localparam int            CNT_LIMIT = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;

   sweep_state_t  state, state_next;
   logic [DW-1:0] lo, hi, code, trial_cnt, hold_code;
   logic [DW-1:0] mid, trial_code, lo_upd, hi_upd;
   logic [DW:0]   mid_sum;
   logic [CNT_W-1:0] cnt;
   logic          first, no_pass, q_lat;
   logic          fin_s, fin_d, fin_rise, q_s;

   hold_sweep_sync u_fin_sync (.clk(clk), .rst_n(rst_n), .d(bus.fin_test), .q(fin_s));
   hold_sweep_sync u_q_sync   (.clk(clk), .rst_n(rst_n), .d(bus.q_ok),     .q(q_s));

   assign fin_rise = fin_s & ~fin_d;

   // The code under evaluation is held in `code`; lo/hi are untouched between SETUP and EVAL.
   assign mid_sum    = {1'b0, lo} + {1'b0, hi};
   assign mid        = mid_sum[DW:1];
   assign trial_code = first ? HI_INIT : mid;
   assign hi_upd     = q_lat ? code : hi;
   assign lo_upd     = q_lat ? lo   : code + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (bus.start) state_next = SETUP;
         SETUP:    state_next = SETTLE;
         SETTLE:   if (cnt == CNT_W'(SETTLE_CYC - 1)) state_next = LAUNCH;
         LAUNCH:   state_next = WAIT_FIN;
         WAIT_FIN: begin
            if (fin_rise) state_next = EVAL;
`ifdef HOLD_SWEEP_TIMEOUT_EN
            else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) state_next = DONE;
`endif
         end
         EVAL: begin
            if (first) state_next = (!q_lat || lo == hi) ? DONE : SETUP;
            else       state_next = (lo_upd == hi_upd)   ? DONE : SETUP;
         end
         DONE:     state_next = IDLE;
         default:  state_next = IDLE;
      endcase
      if (bus.abort && state != IDLE) state_next = IDLE;
   end

   // Search datapath; result registers only load on a genuine entry into DONE, so abort leaves them alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo        <= LO_INIT;
         hi        <= HI_INIT;
         code      <= LO_INIT;
         first     <= 1'b1;
         trial_cnt <= '0;
         hold_code <= '0;
         no_pass   <= 1'b0;
         q_lat     <= 1'b0;
         fin_d     <= 1'b0;
         cnt       <= '0;
      end else begin
         fin_d <= fin_s;
         if (state_next != state)              cnt <= '0;
         else if (cnt != CNT_W'(CNT_LIMIT))    cnt <= cnt + 1'b1;

         case (state)
            IDLE: if (bus.start) begin
               lo        <= LO_INIT;
               hi        <= HI_INIT;
               first     <= 1'b1;
               trial_cnt <= '0;
               no_pass   <= 1'b0;
            end
            SETUP:    code      <= trial_code;
            LAUNCH:   trial_cnt <= trial_cnt + 1'b1;
            WAIT_FIN: if (fin_rise) q_lat <= q_s;
            EVAL: begin
               if (first) begin
                  first <= 1'b0;
               end else begin
                  lo <= lo_upd;
                  hi <= hi_upd;
               end
            end
            default: ;
         endcase

         if (state_next == DONE && state != DONE) begin
            hold_code <= (state == EVAL && !first) ? hi_upd : hi;
            if (state == EVAL && first && !q_lat) no_pass <= 1'b1;
         end
      end
   end

`ifdef HOLD_SWEEP_TIMEOUT_EN
   logic timeout_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                       timeout_err <= 1'b0;
      else if (state == IDLE && bus.start)              timeout_err <= 1'b0;
      else if (state == WAIT_FIN && state_next == DONE) timeout_err <= 1'b1;
   end

   assign bus.timeout_err = timeout_err;
`else
   assign bus.timeout_err = 1'b0;
`endif

   assign bus.delay_code = code;
   assign bus.launch     = (state == LAUNCH);
   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE);
   assign bus.hold_code  = hold_code;
   assign bus.no_pass    = no_pass;
   assign bus.trial_cnt  = trial_cnt;

endmodule

// File: tb/tb_hold_sweep_ctrl.sv
// Directed self-checking bench for hold_sweep_ctrl; models the analog bench as a pass threshold.
module tb_hold_sweep_ctrl;

   logic clk;
   logic rst_n;

   int testsRun;
   int testsFailed;
   int doneSeen;
   int launches;
   int resHold;
   int resNoPass;
   int resTrials;

   hold_sweep_ctrl_if #(.DW(8)) bus ();

   hold_sweep_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input int observed, input int expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Runs one sweep; the bench passes any code >= thr. abortAt>0 aborts during that trial's wait.
   task automatic applyStimulus(input int thr, input int abortAt);
      bit finished;
      finished  = 1'b0;
      doneSeen  = 0;
      launches  = 0;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("busy_after_start", int'(bus.busy), 1);
      for (int c = 0; c < 3000 && !finished; c++) begin
         @(negedge clk);
         if (bus.done) begin
            doneSeen++;
            resHold   = int'(bus.hold_code);
            resNoPass = int'(bus.no_pass);
            resTrials = int'(bus.trial_cnt);
            @(negedge clk);
            checkOutput("done_width", int'(bus.done), 0);
            checkOutput("busy_after_done", int'(bus.busy), 0);
            finished = 1'b1;
         end else if (bus.launch) begin
            launches++;
            if (launches == abortAt) begin
               repeat (3) @(negedge clk);
               bus.abort = 1'b1;
               @(negedge clk);
               bus.abort = 1'b0;
               checkOutput("busy_after_abort", int'(bus.busy), 0);
               repeat (20) begin
                  @(negedge clk);
                  if (bus.done) doneSeen++;
               end
               finished = 1'b1;
            end else begin
               bus.q_ok = (int'(bus.delay_code) >= thr);
               @(negedge clk);
               bus.fin_test = 1'b1;
               repeat (3) @(negedge clk);
               bus.fin_test = 1'b0;
            end
         end
      end
      if (!finished) checkOutput("sweep_bound", 0, 1);
   endtask

   initial begin
      int settleCnt;
      int waited;
      int extraLaunch;
      int busyLow;
      testsRun     = 0;
      testsFailed  = 0;
      bus.start    = 1'b0;
      bus.abort    = 1'b0;
      bus.fin_test = 1'b0;
      bus.q_ok     = 1'b0;
      rst_n        = 1'b0;

      repeat (3) @(negedge clk);
      #1;
      checkOutput("rst_delay_code", int'(bus.delay_code), 0);
      checkOutput("rst_launch", int'(bus.launch), 0);
      checkOutput("rst_busy", int'(bus.busy), 0);
      checkOutput("rst_done", int'(bus.done), 0);
      checkOutput("rst_hold_code", int'(bus.hold_code), 0);
      checkOutput("rst_no_pass", int'(bus.no_pass), 0);
      checkOutput("rst_timeout_err", int'(bus.timeout_err), 0);
      checkOutput("rst_trial_cnt", int'(bus.trial_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Settle timing with a stray fin_test pulse injected before launch
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      waited = 0;
      while (bus.delay_code != 8'd255 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("first_code", int'(bus.delay_code), 255);
      settleCnt = 0;
      for (int c = 0; c < 100; c++) begin
         if (bus.launch) break;
         if (c == 2) bus.fin_test = 1'b1;
         if (c == 6) bus.fin_test = 1'b0;
         @(negedge clk);
         settleCnt++;
      end
      checkOutput("settle_cycles", settleCnt, 16);
      @(negedge clk);
      checkOutput("launch_width", int'(bus.launch), 0);
      checkOutput("trial_cnt_one", int'(bus.trial_cnt), 1);
      extraLaunch = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.launch || bus.done) extraLaunch++;
      end
      checkOutput("stray_fin_ignored", extraLaunch, 0);
      checkOutput("still_waiting", int'(bus.busy), 1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      checkOutput("settle_abort_busy", int'(bus.busy), 0);

      applyStimulus(256, 0);
      checkOutput("failall_done", doneSeen, 1);
      checkOutput("failall_no_pass", resNoPass, 1);
      checkOutput("failall_trials", resTrials, 1);
      checkOutput("failall_launches", launches, 1);

      applyStimulus(100, 0);
      checkOutput("thr100_done", doneSeen, 1);
      checkOutput("thr100_hold", resHold, 100);
      checkOutput("thr100_no_pass", resNoPass, 0);
      checkOutput("thr100_trials", resTrials, 9);

      applyStimulus(0, 0);
      checkOutput("passall_hold", resHold, 0);
      checkOutput("passall_trials", resTrials, 9);

      applyStimulus(255, 0);
      checkOutput("thr255_hold", resHold, 255);
      checkOutput("thr255_no_pass", resNoPass, 0);

      applyStimulus(100, 0);
      checkOutput("reload_hold", resHold, 100);

      applyStimulus(37, 4);
      checkOutput("abort_no_done", doneSeen, 0);
      checkOutput("abort_hold_kept", int'(bus.hold_code), 100);

      applyStimulus(37, 0);
      checkOutput("after_abort_done", doneSeen, 1);
      checkOutput("after_abort_hold", resHold, 37);
      checkOutput("after_abort_trials", resTrials, 9);

      // fin_test never arrives
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      waited = 0;
      while (!bus.launch && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("nofin_launch", int'(bus.launch), 1);
`ifdef HOLD_SWEEP_TIMEOUT_EN
      waited = 0;
      while (!bus.done && waited < 3000) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("timeout_cycles", waited, 1025);
      checkOutput("timeout_err_set", int'(bus.timeout_err), 1);
      @(negedge clk);
      checkOutput("timeout_err_sticky", int'(bus.timeout_err), 1);
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("timeout_err_cleared", int'(bus.timeout_err), 0);
`else
      busyLow = 0;
      repeat (5000) begin
         @(negedge clk);
         if (!bus.busy) busyLow++;
      end
      checkOutput("nofin_busy_held", busyLow, 0);
      checkOutput("nofin_timeout_err", int'(bus.timeout_err), 0);
`endif

      // Asynchronous reset in the middle of a sweep
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (30) @(negedge clk);
      checkOutput("pre_reset_busy", int'(bus.busy), 1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("mid_rst_busy", int'(bus.busy), 0);
      checkOutput("mid_rst_delay_code", int'(bus.delay_code), 0);
      checkOutput("mid_rst_hold_code", int'(bus.hold_code), 0);
      checkOutput("mid_rst_trial_cnt", int'(bus.trial_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
